// File: rtl/whack_a_mole_pkg.sv
// Shared types and helpers for the multi-hole whack-a-mole controller.
// Optional macro MOLE_SPEEDUP_EN is consumed by whack_a_mole_multi_fsm.
package whack_a_mole_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOLE_UP   = 2'd1,
    MOLE_DOWN = 2'd2,
    GAMEOVER  = 2'd3
  } state_t;

  // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10).
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic int ms_ticks(input int clk_hz);
    return clk_hz / 1000;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/whack_a_mole_ms_tick_gen.sv
// Free-running millisecond strobe: one-cycle pulse every CLK_FREQ_HZ/1000 clocks,
// restartable so a new game starts on a whole-millisecond boundary.
module ms_tick_gen
  import whack_a_mole_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic ms_tick
);

  localparam int MS_TICKS = ms_ticks(CLK_FREQ_HZ);
  localparam int DIV_W    = $clog2(MS_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(MS_TICKS - 1);

  logic [DIV_W-1:0] div_q;

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (rst || clear)          div_q <= '0;
    else if (div_q == DIV_MAX) div_q <= '0;
    else                       div_q <= div_q + 1'b1;
  end

  assign ms_tick = (div_q == DIV_MAX);

endmodule

// File: rtl/whack_a_mole_multi_fsm.sv
// Multi-hole whack-a-mole game controller: LFSR hole choice, game countdown, saturating score/miss.
// Define MOLE_SPEEDUP_EN to shorten the mole-up window as the player keeps scoring.
module whack_a_mole_multi_fsm
  import whack_a_mole_pkg::*;
#(
  parameter int          NUM_MOLES    = 4,
  parameter int          CLK_FREQ_HZ  = 50_000_000,
  parameter int          MOLE_UP_MS   = 1000,
  parameter int          MOLE_DOWN_MS = 500,
  parameter int          GAME_MS      = 20000,
  parameter int          SCORE_W      = 8,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_btn,
  input  logic [NUM_MOLES-1:0]           hit_btn,
  output logic [NUM_MOLES-1:0]           mole_up,
  output logic                           game_in_progress,
  output logic [$clog2(GAME_MS+1)-1:0]   time_left_ms,
  output logic [SCORE_W-1:0]             score,
  output logic [SCORE_W-1:0]             misses,
  output logic                           hit_pulse,
  output logic                           miss_pulse,
  output logic [1:0]                     dbg_state
);

  localparam int TIME_W  = $clog2(GAME_MS + 1);
  localparam int HOLE_W  = $clog2(NUM_MOLES);
  localparam int PHASE_W = $clog2(((MOLE_UP_MS > MOLE_DOWN_MS) ? MOLE_UP_MS : MOLE_DOWN_MS) + 1);
  localparam logic [PHASE_W-1:0] UP_FULL = PHASE_W'(MOLE_UP_MS);
  localparam logic [PHASE_W-1:0] DOWN_MS = PHASE_W'(MOLE_DOWN_MS);

  state_t                state_q, state_d;
  logic [15:0]           lfsr_q;
  logic                  start_q;
  logic [NUM_MOLES-1:0]  hit_q;
  logic [HOLE_W-1:0]     hole_q, hole_d;
  logic [NUM_MOLES-1:0]  mole_q, mole_d;
  logic [TIME_W-1:0]     time_q, time_d;
  logic [PHASE_W-1:0]    phase_q, phase_d;
  logic [SCORE_W-1:0]    score_q, score_d, misses_q, misses_d;
  logic                  hit_pulse_q, hit_pulse_d, miss_pulse_q, miss_pulse_d;
  logic [PHASE_W-1:0]    up_ms;

  logic                  start_edge, game_start, ms_tick;
  logic [NUM_MOLES-1:0]  hit_edge;
  logic [HOLE_W-1:0]     raw_hole, next_hole;

`ifdef MOLE_SPEEDUP_EN
  localparam logic [PHASE_W-1:0] UP_STEP  = PHASE_W'(MOLE_UP_MS / 8);
  localparam logic [PHASE_W-1:0] UP_FLOOR = PHASE_W'(MOLE_UP_MS / 4);
  localparam logic [PHASE_W-1:0] UP_KNEE  = PHASE_W'(MOLE_UP_MS / 4 + MOLE_UP_MS / 8);
  logic [PHASE_W-1:0] up_ms_q, up_ms_d;
  logic [1:0]         hit_cnt_q, hit_cnt_d;
  assign up_ms = up_ms_q;
`else
  assign up_ms = UP_FULL;
`endif

  assign start_edge = start_btn & ~start_q;
  assign hit_edge   = hit_btn & ~hit_q;
  assign game_start = start_edge && (state_q == IDLE || state_q == GAMEOVER);

  // hole_q still holds the previous hole while the mole is down, so it doubles as the repeat guard.
  assign raw_hole  = HOLE_W'(lfsr_q % 16'(NUM_MOLES));
  assign next_hole = (raw_hole == hole_q) ?
                     HOLE_W'((32'(raw_hole) + 32'd1) % 32'(NUM_MOLES)) : raw_hole;

  ms_tick_gen #(.CLK_FREQ_HZ(CLK_FREQ_HZ)) u_ms_tick (
    .clk     (clk),
    .rst     (rst),
    .clear   (game_start),
    .ms_tick (ms_tick)
  );

  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    state_d      = state_q;
    hole_d       = hole_q;
    mole_d       = mole_q;
    time_d       = time_q;
    phase_d      = phase_q;
    score_d      = score_q;
    misses_d     = misses_q;
    hit_pulse_d  = 1'b0;
    miss_pulse_d = 1'b0;
`ifdef MOLE_SPEEDUP_EN
    up_ms_d      = up_ms_q;
    hit_cnt_d    = hit_cnt_q;
`endif
    case (state_q)
      IDLE, GAMEOVER: begin
        if (game_start) begin
          state_d  = MOLE_UP;
          hole_d   = raw_hole;
          mole_d   = NUM_MOLES'(1) << raw_hole;
          time_d   = TIME_W'(GAME_MS);
          phase_d  = UP_FULL;
          score_d  = '0;
          misses_d = '0;
`ifdef MOLE_SPEEDUP_EN
          up_ms_d   = UP_FULL;
          hit_cnt_d = '0;
`endif
        end
      end
      MOLE_UP, MOLE_DOWN: begin
        if (time_q == '0) begin
          state_d = GAMEOVER;
          mole_d  = '0;
        end else begin
          if (ms_tick) begin
            time_d = time_q - 1'b1;
            if (phase_q != '0) phase_d = phase_q - 1'b1;
          end
          if (state_q == MOLE_UP) begin
            if (hit_edge[hole_q]) begin
              score_d     = (&score_q) ? score_q : score_q + 1'b1;
              hit_pulse_d = 1'b1;
              state_d     = MOLE_DOWN;
              mole_d      = '0;
              phase_d     = DOWN_MS;
`ifdef MOLE_SPEEDUP_EN
              hit_cnt_d = hit_cnt_q + 1'b1;
              if (hit_cnt_q == 2'd3)
                up_ms_d = (up_ms_q > UP_KNEE) ? up_ms_q - UP_STEP : UP_FLOOR;
`endif
            end else if ((|hit_edge) || phase_q == '0) begin
              misses_d     = (&misses_q) ? misses_q : misses_q + 1'b1;
              miss_pulse_d = 1'b1;
              if (phase_q == '0) begin
                state_d = MOLE_DOWN;
                mole_d  = '0;
                phase_d = DOWN_MS;
              end
            end
          end else if (phase_q == '0) begin
            state_d = MOLE_UP;
            hole_d  = next_hole;
            mole_d  = NUM_MOLES'(1) << next_hole;
            phase_d = up_ms;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // Edge registers sample the live buttons during reset so a held button yields no edge.
    start_q <= start_btn;
    hit_q   <= hit_btn;
    if (rst) begin
      state_q      <= IDLE;
      lfsr_q       <= LFSR_SEED;
      hole_q       <= '0;
      mole_q       <= '0;
      time_q       <= TIME_W'(GAME_MS);
      phase_q      <= '0;
      score_q      <= '0;
      misses_q     <= '0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
      up_ms_q      <= UP_FULL;
      hit_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lfsr_q       <= lfsr_next(lfsr_q);
      hole_q       <= hole_d;
      mole_q       <= mole_d;
      time_q       <= time_d;
      phase_q      <= phase_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      hit_pulse_q  <= hit_pulse_d;
      miss_pulse_q <= miss_pulse_d;
`ifdef MOLE_SPEEDUP_EN
      up_ms_q      <= up_ms_d;
      hit_cnt_q    <= hit_cnt_d;
`endif
    end
  end

  assign mole_up          = mole_q;
  assign game_in_progress = (state_q == MOLE_UP) || (state_q == MOLE_DOWN);
  assign time_left_ms     = time_q;
  assign score            = score_q;
  assign misses           = misses_q;
  assign hit_pulse        = hit_pulse_q;
  assign miss_pulse       = miss_pulse_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_whack_a_mole_multi_fsm.sv
// Scoreboard bench for whack_a_mole_multi_fsm: a game-rule model predicts every cycle's outputs,
// a separate monitor compares them against the DUT one step after each clock edge.
module tb_whack_a_mole_multi_fsm;
  import whack_a_mole_pkg::*;

  localparam int          N       = 4;
  localparam int          CLK_HZ  = 10_000;
  localparam int          UP_MS   = 20;
  localparam int          DOWN_MS = 10;
  localparam int          GAME    = 100;
  localparam int          SW      = 3;
  localparam logic [15:0] SEED    = 16'hACE1;
  localparam int          TW      = $clog2(GAME + 1);
  localparam int          CPM     = CLK_HZ / 1000;
  localparam int          SMAX    = (1 << SW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start_btn = 1'b1;
  logic [N-1:0]  hit_btn = '0;
  logic [N-1:0]  mole_up;
  logic          game_in_progress;
  logic [TW-1:0] time_left_ms;
  logic [SW-1:0] score, misses;
  logic          hit_pulse, miss_pulse;
  logic [1:0]    dbg_state;

  whack_a_mole_multi_fsm #(
    .NUM_MOLES(N), .CLK_FREQ_HZ(CLK_HZ), .MOLE_UP_MS(UP_MS), .MOLE_DOWN_MS(DOWN_MS),
    .GAME_MS(GAME), .SCORE_W(SW), .LFSR_SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn), .hit_btn(hit_btn),
    .mole_up(mole_up), .game_in_progress(game_in_progress), .time_left_ms(time_left_ms),
    .score(score), .misses(misses), .hit_pulse(hit_pulse), .miss_pulse(miss_pulse),
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  mole;
    logic          gip;
    logic [TW-1:0] tl;
    logic [SW-1:0] sc;
    logic [SW-1:0] ms;
    logic          hp;
    logic          mp;
    logic [1:0]    st;
  } obs_t;

  obs_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Game-rule model: times are counted in whole milliseconds since game/phase start.
  state_t       m_state;
  logic [15:0]  m_lfsr;
  logic         m_start_prev;
  logic [N-1:0] m_hit_prev;
  int m_cycle = 0, m_anchor = 0, m_hole = -1, m_last_hole = 0;
  int m_game_ms, m_phase_ms, m_phase_len, m_score, m_misses, m_up_ms, m_hits;
  bit m_hp, m_mp;

  task automatic enter_up(input int h);
    m_state = MOLE_UP; m_hole = h; m_last_hole = h; m_phase_ms = 0; m_phase_len = m_up_ms;
  endtask

  task automatic enter_down();
    m_state = MOLE_DOWN; m_hole = -1; m_phase_ms = 0; m_phase_len = DOWN_MS;
  endtask

  task automatic model_step(input bit r, input bit st, input logic [N-1:0] h);
    bit           start_e, tick, expired;
    logic [N-1:0] he;
    int           pick;
    obs_t         e;
    m_hp = 0; m_mp = 0;
    if (r) begin
      m_state = IDLE; m_hole = -1; m_game_ms = 0; m_score = 0; m_misses = 0;
      m_lfsr = SEED; m_up_ms = UP_MS; m_hits = 0; m_anchor = m_cycle;
    end else begin
      start_e = st && !m_start_prev;
      he      = h & ~m_hit_prev;
      tick    = (m_cycle > m_anchor) && ((m_cycle - m_anchor) % CPM == 0);
      if (m_state == IDLE || m_state == GAMEOVER) begin
        if (start_e) begin
          m_score = 0; m_misses = 0; m_game_ms = 0; m_up_ms = UP_MS; m_hits = 0;
          m_anchor = m_cycle;
          enter_up(int'(m_lfsr) % N);
        end
      end else if (m_game_ms >= GAME) begin
        m_state = GAMEOVER; m_hole = -1;
      end else begin
        expired = (m_phase_ms >= m_phase_len);
        if (tick) begin m_game_ms++; m_phase_ms++; end
        if (m_state == MOLE_UP) begin
          if (he[m_hole]) begin
            if (m_score < SMAX) m_score++;
            m_hp = 1; m_hits++;
`ifdef MOLE_SPEEDUP_EN
            if (m_hits % 4 == 0) m_up_ms = (m_up_ms - UP_MS / 8 > UP_MS / 4) ? m_up_ms - UP_MS / 8 : UP_MS / 4;
`endif
            enter_down();
          end else if (he != 0 || expired) begin
            if (m_misses < SMAX) m_misses++;
            m_mp = 1;
            if (expired) enter_down();
          end
        end else if (expired) begin
          pick = int'(m_lfsr) % N;
          if (pick == m_last_hole) pick = (pick + 1) % N;
          enter_up(pick);
        end
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
    m_start_prev = st; m_hit_prev = h; m_cycle++;
    e.mole = (m_hole >= 0) ? (N'(1) << m_hole) : '0;
    e.gip  = (m_state == MOLE_UP || m_state == MOLE_DOWN);
    e.tl   = (m_state == GAMEOVER) ? '0 : TW'(GAME - m_game_ms);
    e.sc   = SW'(m_score);
    e.ms   = SW'(m_misses);
    e.hp   = m_hp;
    e.mp   = m_mp;
    e.st   = m_state;
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit r, input bit st, input logic [N-1:0] h);
    @(negedge clk);
    rst = r; start_btn = st; hit_btn = h;
    model_step(r, st, h);
  endtask

  // Monitor: every clock edge presents a new output set; compare it with the oldest prediction.
  obs_t got, want;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got  = '{mole_up, game_in_progress, time_left_ms, score, misses, hit_pulse, miss_pulse, dbg_state};
        n_cmp++;
        if (got !== want) begin
          n_bad++;
          $display("FAIL outputs t=%0t got mole=%b gip=%b tl=%0d sc=%0d ms=%0d hp=%b mp=%b st=%0d | required mole=%b gip=%b tl=%0d sc=%0d ms=%0d hp=%b mp=%b st=%0d",
                   $time, got.mole, got.gip, got.tl, got.sc, got.ms, got.hp, got.mp, got.st,
                   want.mole, want.gip, want.tl, want.sc, want.ms, want.hp, want.mp, want.st);
        end
      end
    end
  end

  // mode 0: never press; 1: chase the active mole; 2: random button mash; 3: press only as time runs out.
  task automatic play_game(input int gnum, input int mode, input bit mid_rst);
    logic [N-1:0] h;
    bit           st;
    int           c;
    repeat ($urandom_range(2, 40)) drive(0, 0, '0);
    drive(0, 1, '0);
    for (c = 0; c < 3000 && m_state != GAMEOVER; c++) begin
      if (mid_rst && c == 300) begin
        drive(1, 0, '0);
        drive(1, 0, '0);
        return;
      end
      h  = '0;
      st = 0;
      case (mode)
        1: if (m_state == MOLE_UP && $urandom_range(0, 7) == 0) h = N'(1) << m_hole;
        2: begin
          if ($urandom_range(0, 11) == 0) h = N'($urandom_range(1, (1 << N) - 1));
          st = ($urandom_range(0, 49) == 0);
        end
        3: if (m_state == MOLE_UP && m_game_ms >= GAME) h = N'(1) << m_hole;
        default: h = '0;
      endcase
      drive(0, st, h);
    end
    if (m_state != GAMEOVER) begin
      n_cmp++;
      n_bad++;
      $display("FAIL game_budget: game %0d state=%0d after %0d cycles, required GAMEOVER", gnum, m_state, c);
    end
  endtask

  initial begin
    // start_btn is held high through reset and released later: no start edge may be seen.
    repeat (4) drive(1, 1, '0);
    for (int i = 0; i < 1000; i++)
      drive(0, i < 50, ($urandom_range(0, 19) == 0) ? N'($urandom_range(1, (1 << N) - 1)) : '0);
    for (int g = 0; g < 10; g++)
      play_game(g, g % 4, g == 5);
    repeat (3) drive(0, 0, '0);
    @(posedge clk);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d predictions left unchecked, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
